// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel-rate divider, h/v counters,
// registered sync/video decode, line/frame pulses and a frame counter.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 10,
    parameter int FW       = 8
) (
    input  logic          CLK,
    input  logic          rst,
    input  logic          en,
    output logic          pix_tick,
    output logic          h_sync,
    output logic          v_sync,
    output logic          video_on,
    output logic [CW-1:0] x_pos,
    output logic [CW-1:0] y_pos,
    output logic          line_start,
    output logic          frame_start,
    output logic [FW-1:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] div;
    logic [DW-1:0] div_nx;
    logic [CW-1:0] h_nx;
    logic [CW-1:0] v_nx;
    logic [FW-1:0] fc_nx;
    logic          tick;
    logic          line_wrap;
    logic          frame_wrap;

    // x_pos/y_pos/frame_count double as the raster state; decode uses the next
    // state so every output lines up with the pulse that caused it.
    always_comb begin
        tick       = en && (div == DIV_LAST);
        div_nx     = div;
        h_nx       = x_pos;
        v_nx       = y_pos;
        fc_nx      = frame_count;
        line_wrap  = 1'b0;
        frame_wrap = 1'b0;
        if (en) begin
            div_nx = (div == DIV_LAST) ? '0 : div + 1'b1;
        end
        if (tick) begin
            if (x_pos == H_LAST) begin
                h_nx      = '0;
                line_wrap = 1'b1;
                if (y_pos == V_LAST) begin
                    v_nx       = '0;
                    fc_nx      = frame_count + 1'b1;
                    frame_wrap = 1'b1;
                end else begin
                    v_nx = y_pos + 1'b1;
                end
            end else begin
                h_nx = x_pos + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            div         <= '0;
            x_pos       <= '0;
            y_pos       <= '0;
            frame_count <= '0;
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            h_sync      <= ~HS_POL;
            v_sync      <= ~VS_POL;
            video_on    <= 1'b0;
        end else begin
            div         <= div_nx;
            x_pos       <= h_nx;
            y_pos       <= v_nx;
            frame_count <= fc_nx;
            pix_tick    <= tick;
            line_start  <= line_wrap;
            frame_start <= frame_wrap;
            h_sync      <= (h_nx >= HS_START && h_nx < HS_END) ? HS_POL : ~HS_POL;
            v_sync      <= (v_nx >= VS_START && v_nx < VS_END) ? VS_POL : ~VS_POL;
            video_on    <= (h_nx < H_VIS) && (v_nx < V_VIS);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480, small raster at
// CLK_DIV=1 and CLK_DIV=3) checked against an arithmetic raster model.
module tb_vga_timing_gen;

    typedef struct {
        int unsigned ha, hfp, hs, hbp, va, vfp, vs, vbp, div, fw;
        bit          hpol, vpol;
    } cfg_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst;
    logic [2:0] en;

    logic       pt0, hs0, vs0, vo0, ls0, fs0;
    logic [9:0] x0, y0;
    logic [7:0] fc0;
    logic       pt1, hs1, vs1, vo1, ls1, fs1;
    logic [9:0] x1, y1;
    logic [1:0] fc1;
    logic       pt2, hs2, vs2, vo2, ls2, fs2;
    logic [9:0] x2, y2;
    logic [7:0] fc2;

    cfg_t        cfg [3];
    int unsigned n   [3] = '{0, 0, 0};
    bit          tk  [3] = '{0, 0, 0};
    bit          rq  [3] = '{1, 1, 1};
    int          total = 0;
    int          bad   = 0;

    vga_timing_gen u0 (
        .CLK(clk), .rst(rst[0]), .en(en[0]), .pix_tick(pt0), .h_sync(hs0),
        .v_sync(vs0), .video_on(vo0), .x_pos(x0), .y_pos(y0),
        .line_start(ls0), .frame_start(fs0), .frame_count(fc0)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(10), .FW(2)
    ) u1 (
        .CLK(clk), .rst(rst[1]), .en(en[1]), .pix_tick(pt1), .h_sync(hs1),
        .v_sync(vs1), .video_on(vo1), .x_pos(x1), .y_pos(y1),
        .line_start(ls1), .frame_start(fs1), .frame_count(fc1)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(10), .FW(8)
    ) u2 (
        .CLK(clk), .rst(rst[2]), .en(en[2]), .pix_tick(pt2), .h_sync(hs2),
        .v_sync(vs2), .video_on(vo2), .x_pos(x2), .y_pos(y2),
        .line_start(ls2), .frame_start(fs2), .frame_count(fc2)
    );

    // Model state: enabled edges since reset, whether this edge ticked, reset seen.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst[i]) begin
                n[i]  <= 0;
                tk[i] <= 1'b0;
                rq[i] <= 1'b1;
            end else begin
                rq[i] <= 1'b0;
                if (en[i]) begin
                    n[i]  <= n[i] + 1;
                    tk[i] <= ((n[i] + 1) % cfg[i].div) == 0;
                end else begin
                    tk[i] <= 1'b0;
                end
            end
        end
    end

    // Pixel index is enabled-edges / CLK_DIV; everything else follows from it.
    function automatic logic [33:0] model(input cfg_t c, input int unsigned cnt,
                                          input bit ticked, input bit in_rst);
        int unsigned ht, vt, p, h, ln, v, f;
        bit hsa, vsa, von, ls, fs, hso, vso;
        if (in_rst) return {1'b0, ~c.hpol, ~c.vpol, 1'b0, 20'd0, 2'b00, 8'd0};
        ht  = c.ha + c.hfp + c.hs + c.hbp;
        vt  = c.va + c.vfp + c.vs + c.vbp;
        p   = cnt / c.div;
        h   = p % ht;
        ln  = p / ht;
        v   = ln % vt;
        f   = (ln / vt) % (1 << c.fw);
        hsa = (h >= c.ha + c.hfp) && (h < c.ha + c.hfp + c.hs);
        vsa = (v >= c.va + c.vfp) && (v < c.va + c.vfp + c.vs);
        von = (h < c.ha) && (v < c.va);
        ls  = ticked && (h == 0);
        fs  = ls && (v == 0);
        hso = hsa ? c.hpol : ~c.hpol;
        vso = vsa ? c.vpol : ~c.vpol;
        return {ticked, hso, vso, von, 10'(h), 10'(v), ls, fs, 8'(f)};
    endfunction

    function automatic logic [33:0] obs_of(input int i);
        case (i)
            0:       return {pt0, hs0, vs0, vo0, x0, y0, ls0, fs0, fc0};
            1:       return {pt1, hs1, vs1, vo1, x1, y1, ls1, fs1, 6'd0, fc1};
            default: return {pt2, hs2, vs2, vo2, x2, y2, ls2, fs2, fc2};
        endcase
    endfunction

    task automatic test_reset;
        logic [33:0] want, got;
        rst = '1;
        en  = '1;
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                want = model(cfg[i], n[i], tk[i], rq[i]);
                got  = obs_of(i);
                total++;
                if (got !== want) begin
                    bad++;
                    $display("[TB] FAIL reset_state dut%0d t=%0t got=%h want=%h", i, $time, got, want);
                end
            end
        end
        rst = '0;
        @(negedge clk);
        total++;
        if ({vo0, x0, y0, hs0, vs0, pt0} !== {1'b1, 20'd0, 2'b11, 1'b0}) begin
            bad++;
            $display("[TB] FAIL first_edge_d0 got=%b want=%b", {vo0, x0, y0, hs0, vs0, pt0}, {1'b1, 20'd0, 2'b11, 1'b0});
        end
        total++;
        if ({vo2, x2, y2, hs2, vs2, pt2} !== {1'b1, 20'd0, 2'b11, 1'b0}) begin
            bad++;
            $display("[TB] FAIL first_edge_d2 got=%b want=%b", {vo2, x2, y2, hs2, vs2, pt2}, {1'b1, 20'd0, 2'b11, 1'b0});
        end
        for (int i = 0; i < 3; i++) begin
            want = model(cfg[i], n[i], tk[i], rq[i]);
            got  = obs_of(i);
            total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL first_edge_model dut%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_default_line;
        logic [33:0] want, got;
        int cyc = 0, last_ls = -1, hs_start = -1, vcount = 0, nls = 0;
        logic prev_hs = 1'b1;
        for (int k = 0; k < 4810; k++) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 3; i++) begin
                want = model(cfg[i], n[i], tk[i], rq[i]);
                got  = obs_of(i);
                total++;
                if (got !== want) begin
                    bad++;
                    $display("[TB] FAIL default_model dut%0d t=%0t got=%h want=%h", i, $time, got, want);
                end
            end
            if (ls0) begin
                nls++;
                if (last_ls >= 0) begin
                    total++;
                    if (cyc - last_ls != 1600) begin
                        bad++;
                        $display("[TB] FAIL line_period got=%0d want=1600", cyc - last_ls);
                    end
                    total++;
                    if (vcount != 1280) begin
                        bad++;
                        $display("[TB] FAIL video_on_per_line got=%0d want=1280", vcount);
                    end
                end
                last_ls = cyc;
                vcount  = 0;
            end
            if (vo0) vcount++;
            if (prev_hs && !hs0) begin
                total++;
                if (x0 !== 10'd656) begin
                    bad++;
                    $display("[TB] FAIL hsync_start_x got=%0d want=656", x0);
                end
                hs_start = cyc;
            end
            if (!prev_hs && hs0 && hs_start >= 0) begin
                total++;
                if (cyc - hs_start != 192) begin
                    bad++;
                    $display("[TB] FAIL hsync_width got=%0d want=192", cyc - hs_start);
                end
            end
            prev_hs = hs0;
        end
        total++;
        if (nls < 3) begin
            bad++;
            $display("[TB] FAIL line_start_count got=%0d want>=3", nls);
        end
    endtask

    task automatic test_small_raster;
        logic [33:0] want, got;
        int cyc = 0, last_fs = -1, nfs = 0, prev_x = 0;
        @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        rst[1] = 1'b0;
        for (int k = 0; k < 610; k++) begin
            @(negedge clk);
            cyc++;
            want = model(cfg[1], n[1], tk[1], rq[1]);
            got  = obs_of(1);
            total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL small_model t=%0t got=%h want=%h", $time, got, want);
            end
            total++;
            if (x1 !== 10'((prev_x + 1) % 15)) begin
                bad++;
                $display("[TB] FAIL x_step got=%0d want=%0d", x1, (prev_x + 1) % 15);
            end
            prev_x = int'(x1);
            total++;
            if (hs1 !== (x1 >= 10 && x1 <= 12)) begin
                bad++;
                $display("[TB] FAIL hsync_window x=%0d got=%b", x1, hs1);
            end
            total++;
            if (vs1 !== (y1 >= 5 && y1 <= 6)) begin
                bad++;
                $display("[TB] FAIL vsync_window y=%0d got=%b", y1, vs1);
            end
            total++;
            if (pt1 !== 1'b1) begin
                bad++;
                $display("[TB] FAIL pix_tick_every_cycle got=%b want=1", pt1);
            end
            if (fs1) begin
                nfs++;
                total++;
                if ({ls1, x1, y1} !== {1'b1, 20'd0}) begin
                    bad++;
                    $display("[TB] FAIL wrap_align got ls=%b x=%0d y=%0d want ls=1 x=0 y=0", ls1, x1, y1);
                end
                total++;
                if (fc1 !== 2'(nfs % 4)) begin
                    bad++;
                    $display("[TB] FAIL frame_count_seq got=%0d want=%0d", fc1, nfs % 4);
                end
                if (last_fs >= 0) begin
                    total++;
                    if (cyc - last_fs != 120) begin
                        bad++;
                        $display("[TB] FAIL frame_period got=%0d want=120", cyc - last_fs);
                    end
                end
                last_fs = cyc;
            end
        end
        total++;
        if (nfs < 5) begin
            bad++;
            $display("[TB] FAIL frame_start_count got=%0d want>=5", nfs);
        end
    endtask

    task automatic test_enable_gating;
        logic [33:0] want, got;
        logic [9:0]  hold_x, hold_y, prev_x;
        bit found = 0;
        int cyc = 0, last = -1, cnt = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (x2 == 10'd4) found = 1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("[TB] FAIL gate_wait got=timeout want=x_pos 4");
        end
        @(negedge clk);
        hold_x = x2;
        hold_y = y2;
        en[2]  = 1'b0;
        repeat (7) begin
            @(negedge clk);
            want = model(cfg[2], n[2], tk[2], rq[2]);
            got  = obs_of(2);
            total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL gate_model t=%0t got=%h want=%h", $time, got, want);
            end
            total++;
            if ({x2, y2} !== {hold_x, hold_y}) begin
                bad++;
                $display("[TB] FAIL gate_hold got=%0d,%0d want=%0d,%0d", x2, y2, hold_x, hold_y);
            end
            total++;
            if ({pt2, ls2} !== 2'b00) begin
                bad++;
                $display("[TB] FAIL gate_pulses got=%b want=00", {pt2, ls2});
            end
        end
        en[2]  = 1'b1;
        prev_x = x2;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            cyc++;
            want = model(cfg[2], n[2], tk[2], rq[2]);
            got  = obs_of(2);
            total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL resume_model t=%0t got=%h want=%h", $time, got, want);
            end
            total++;
            if (pt2 !== (x2 != prev_x)) begin
                bad++;
                $display("[TB] FAIL tick_x_align got tick=%b x=%0d prev=%0d", pt2, x2, prev_x);
            end
            prev_x = x2;
            if (pt2) begin
                if (last >= 0) begin
                    total++;
                    if (cyc - last != 3) begin
                        bad++;
                        $display("[TB] FAIL tick_spacing got=%0d want=3", cyc - last);
                    end
                end
                last = cyc;
                cnt++;
            end
        end
        total++;
        if (cnt < 10) begin
            bad++;
            $display("[TB] FAIL resume_tick_count got=%0d want>=10", cnt);
        end
    endtask

    task automatic test_reset_midframe;
        logic [33:0] want, got;
        bit found = 0;
        int c = 0;
        for (int k = 0; k < 2000 && !found; k++) begin
            @(negedge clk);
            if (x2 == 10'd5 && y2 == 10'd3) found = 1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("[TB] FAIL midframe_wait got=timeout want=(5,3)");
        end
        rst[2] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            total++;
            if ({x2, y2, vo2, fs2, ls2, pt2, fc2, hs2, vs2} !== {32'd0, 2'b11}) begin
                bad++;
                $display("[TB] FAIL reset_hold got=%h want=%h", {x2, y2, vo2, fs2, ls2, pt2, fc2, hs2, vs2}, {32'd0, 2'b11});
            end
        end
        rst[2] = 1'b0;
        @(negedge clk);
        c = 1;
        total++;
        if ({x2, y2, vo2} !== {20'd0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL release_edge got x=%0d y=%0d von=%b want 0 0 1", x2, y2, vo2);
        end
        found = 0;
        for (int k = 0; k < 500 && !found; k++) begin
            @(negedge clk);
            c++;
            want = model(cfg[2], n[2], tk[2], rq[2]);
            got  = obs_of(2);
            total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL post_reset_model t=%0t got=%h want=%h", $time, got, want);
            end
            if (fs2) found = 1;
        end
        total++;
        if (!found || c != 360) begin
            bad++;
            $display("[TB] FAIL first_frame_start got=%0d want=360", found ? c : -1);
        end
    endtask

    task automatic test_random;
        logic [33:0] want, got;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                want = model(cfg[i], n[i], tk[i], rq[i]);
                got  = obs_of(i);
                total++;
                if (got !== want) begin
                    bad++;
                    $display("[TB] FAIL random_model dut%0d t=%0t got=%h want=%h", i, $time, got, want);
                end
            end
            for (int i = 0; i < 3; i++) begin
                en[i]  = ($urandom_range(0, 9) != 0);
                rst[i] = ($urandom_range(0, 199) == 0);
            end
        end
    endtask

    initial begin
        cfg[0] = '{ha:640, hfp:16, hs:96, hbp:48, va:480, vfp:10, vs:2, vbp:33, div:2, fw:8, hpol:1'b0, vpol:1'b0};
        cfg[1] = '{ha:8, hfp:2, hs:3, hbp:2, va:4, vfp:1, vs:2, vbp:1, div:1, fw:2, hpol:1'b1, vpol:1'b1};
        cfg[2] = '{ha:8, hfp:2, hs:3, hbp:2, va:4, vfp:1, vs:2, vbp:1, div:3, fw:8, hpol:1'b0, vpol:1'b0};
        rst = '1;
        en  = '1;
        test_reset();
        test_default_line();
        test_small_raster();
        test_enable_gating();
        test_reset_midframe();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
